// File: rtl/sva_verdict_pkg.sv
// Shared types for the SVA verdict tracker slice.
// Record layout, verdict encodings and tracker states.
package sva_verdict_pkg;

  typedef enum logic [1:0] {
    KIND_SUCC = 2'd0,
    KIND_FAIL = 2'd1,
    KIND_LAZY = 2'd2,
    KIND_RSVD = 2'd3
  } verdict_kind_t;

  typedef enum logic [1:0] {
    V_PENDING = 2'd0,
    V_PASS    = 2'd1,
    V_FAIL    = 2'd2,
    V_VACUOUS = 2'd3
  } verdict_t;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FAILED = 2'd1,
    ST_CLOSED = 2'd2
  } tracker_state_t;

  localparam int unsigned REC_TW = 8;

  typedef struct packed {
    verdict_kind_t     kind;
    logic [REC_TW-1:0] start;
    logic [REC_TW-1:0] stop;
  } verdict_rec_t;

endpackage

// File: rtl/sva_rec_fifo.sv
// Registered sync FIFO of verdict records.
// A pop in the same cycle frees a slot for a push into a full FIFO.
module sva_rec_fifo
  import sva_verdict_pkg::*;
#(
  parameter type         REC_T = verdict_rec_t,
  parameter int unsigned DEPTH = 4
) (
  input  logic gclk,
  input  logic grst,
  input  logic push,
  input  REC_T wdata,
  input  logic pop,
  output REC_T head,
  output logic full,
  output logic empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_N = (AW+1)'(DEPTH);

  REC_T          mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == FULL_N);
  assign empty   = (cnt == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rp];

  always_ff @(posedge gclk or posedge grst) begin
    if (grst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge gclk) begin
    if (do_push) mem[wp] <= wdata;
  end

endmodule

// File: rtl/sva_verdict_tracker.sv
// Timestamps SVA verdict events, buffers them, counts them, keeps a sticky verdict.
// Optional SVA_VERDICT_LATENCY_EN adds lat_min/lat_max over SUCC/LAZY events.
module sva_verdict_tracker
  import sva_verdict_pkg::*;
#(
  parameter int unsigned TIMER_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                   gclk,
  input  logic                   grst,
  input  logic                   ev_valid,
  input  logic [1:0]             ev_kind,
  input  logic [TIMER_WIDTH-1:0] ev_start,
  input  logic                   eot,
  output logic                   rec_valid,
  input  logic                   rec_ready,
  output logic [1:0]             rec_kind,
  output logic [TIMER_WIDTH-1:0] rec_start,
  output logic [TIMER_WIDTH-1:0] rec_end,
  output logic [CNT_WIDTH-1:0]   succ_cnt,
  output logic [CNT_WIDTH-1:0]   fail_cnt,
  output logic [CNT_WIDTH-1:0]   lazy_cnt,
  output logic [CNT_WIDTH-1:0]   drop_cnt,
  output logic [1:0]             verdict,
  output logic [TIMER_WIDTH-1:0] first_fail_end,
  output logic                   done
`ifdef SVA_VERDICT_LATENCY_EN
  ,
  output logic [TIMER_WIDTH-1:0] lat_min,
  output logic [TIMER_WIDTH-1:0] lat_max
`endif
);

  typedef struct packed {
    verdict_kind_t          kind;
    logic [TIMER_WIDTH-1:0] start;
    logic [TIMER_WIDTH-1:0] stop;
  } rec_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  tracker_state_t         state;
  verdict_t               vq;
  verdict_kind_t          kind;
  logic [TIMER_WIDTH-1:0] per;
  logic                   acc;
  logic                   acc_succ;
  logic                   acc_fail;
  logic                   acc_lazy;
  logic                   any_ok;
  logic                   rd;
  logic                   full;
  logic                   empty;
  logic                   drop;
  rec_t                   wrec;
  rec_t                   hrec;

  assign kind = verdict_kind_t'(ev_kind);
  assign acc  = ev_valid & (kind != KIND_RSVD)
              & (state != ST_CLOSED);

  always_comb begin
    acc_succ = 1'b0;
    acc_fail = 1'b0;
    acc_lazy = 1'b0;
    unique case (1'b1)
      (kind == KIND_SUCC): acc_succ = acc;
      (kind == KIND_FAIL): acc_fail = acc;
      (kind == KIND_LAZY): acc_lazy = acc;
      default: ;
    endcase
  end

  assign rec_valid = ~empty;
  assign rd        = rec_valid & rec_ready;
  assign drop      = acc & full & ~rd;

  assign wrec.kind  = kind;
  assign wrec.start = ev_start;
  assign wrec.stop  = per;

  sva_rec_fifo #(
    .REC_T (rec_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .gclk  (gclk),
    .grst  (grst),
    .push  (acc),
    .wdata (wrec),
    .pop   (rd),
    .head  (hrec),
    .full  (full),
    .empty (empty)
  );

  assign rec_kind  = hrec.kind;
  assign rec_start = hrec.start;
  assign rec_end   = hrec.stop;
  assign verdict   = vq;

  always_ff @(posedge gclk or posedge grst) begin
    if (grst) per <= '0;
    else      per <= per + TIMER_WIDTH'(1);
  end

  always_ff @(posedge gclk or posedge grst) begin
    if (grst) begin
      succ_cnt <= '0;
      fail_cnt <= '0;
      lazy_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (acc_succ && succ_cnt != '1)
        succ_cnt <= succ_cnt + CNT_ONE;
      if (acc_fail && fail_cnt != '1)
        fail_cnt <= fail_cnt + CNT_ONE;
      if (acc_lazy && lazy_cnt != '1)
        lazy_cnt <= lazy_cnt + CNT_ONE;
      if (drop && drop_cnt != '1)
        drop_cnt <= drop_cnt + CNT_ONE;
    end
  end

  // Same-cycle success counts toward PASS when eot closes the run.
  assign any_ok = (succ_cnt != '0) | (lazy_cnt != '0)
                | acc_succ | acc_lazy;

  always_ff @(posedge gclk or posedge grst) begin
    if (grst) begin
      state          <= ST_RUN;
      vq             <= V_PENDING;
      done           <= 1'b0;
      first_fail_end <= '0;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (acc_fail) first_fail_end <= per;
          if (eot) begin
            state <= ST_CLOSED;
            done  <= 1'b1;
            if (acc_fail)    vq <= V_FAIL;
            else if (any_ok) vq <= V_PASS;
            else             vq <= V_VACUOUS;
          end else if (acc_fail) begin
            state <= ST_FAILED;
            vq    <= V_FAIL;
          end
        end
        ST_FAILED: begin
          if (eot) begin
            state <= ST_CLOSED;
            done  <= 1'b1;
          end
        end
        ST_CLOSED: done <= 1'b1;
        default:   state <= ST_RUN;
      endcase
    end
  end

`ifdef SVA_VERDICT_LATENCY_EN
  logic [TIMER_WIDTH-1:0] lat;

  assign lat = per - ev_start;

  always_ff @(posedge gclk or posedge grst) begin
    if (grst) begin
      lat_min <= '1;
      lat_max <= '0;
    end else if (acc_succ || acc_lazy) begin
      if (lat < lat_min) lat_min <= lat;
      if (lat > lat_max) lat_max <= lat;
    end
  end
`endif

endmodule

// File: doc/sva_verdict_tracker.md
Name: sva_verdict_tracker

Overview:
- Downstream consumer of the SVA checker FSM.
- Receives one verdict event per gclk cycle (succ / fail / lazy_succ plus the attempt's start_period) and timestamps it with its own period counter.
- Buffers records in a small FIFO for a log/readout drain, keeps saturating counters, and latches a sticky overall verdict closed by an end-of-test strobe.

Parameters:
- TIMER_WIDTH, 8, width of period counter and start/end timestamps.
- FIFO_DEPTH, 4, record FIFO entries; power of two, at least 2.
- CNT_WIDTH, 16, width of each saturating event counter.

Ports:
- gclk  in  1  user clock.
- grst  in  1  reset, asynchronous, active-high.
- ev_valid  in  1  verdict event present this cycle; no back-pressure.
- ev_kind  in  2  0=SUCC, 1=FAIL, 2=LAZY, 3=reserved.
- ev_start  in  TIMER_WIDTH  start_period of the finishing attempt.
- eot  in  1  end-of-test strobe.
- rec_valid  out  1  FIFO head valid.
- rec_ready  in  1  drain accepts head.
- rec_kind  out  2  head kind.
- rec_start  out  TIMER_WIDTH  head start period.
- rec_end  out  TIMER_WIDTH  head end period.
- succ_cnt  out  CNT_WIDTH  SUCC events accepted.
- fail_cnt  out  CNT_WIDTH  FAIL events accepted.
- lazy_cnt  out  CNT_WIDTH  LAZY events accepted.
- drop_cnt  out  CNT_WIDTH  events lost to a full FIFO.
- verdict  out  2  0=PENDING, 1=PASS, 2=FAIL, 3=VACUOUS.
- first_fail_end  out  TIMER_WIDTH  end period of the first FAIL.
- done  out  1  tracker in CLOSED.

Behaviour:
- Reset:
  - All counters, FIFO pointers, rec_valid, done, first_fail_end and the period counter clear to 0.
  - verdict=PENDING; FSM=RUN.
- Period counter: increments every gclk and wraps modulo 2^TIMER_WIDTH. An event's end period is the counter value in the cycle ev_valid is high.
- Accept, all in one cycle, when ev_valid=1 and ev_kind!=3 in RUN or FAILED:
  - FIFO write if not full.
  - Kind counter +1, saturating at all-ones.
- ev_kind=3 is ignored entirely: no count, no write.
- FIFO full on accept: record discarded; drop_cnt +1 (saturating). The kind counter still increments.
- Simultaneous write and read when full: the read frees the slot the same cycle, so the write succeeds and nothing is dropped.
- Drain handshake:
  - Head pops on rec_valid && rec_ready.
  - rec_* stay stable while rec_valid && !rec_ready.
  - The FIFO is registered. An event written into an empty FIFO gives rec_valid=1 on the next cycle (latency 1).
- FSM:
  - RUN --FAIL accepted--> FAILED. first_fail_end is captured; verdict=FAIL on the next cycle.
  - RUN --eot--> CLOSED. verdict=PASS if succ_cnt+lazy_cnt>0, else VACUOUS. This computation includes an event accepted in the same cycle as eot.
  - FAILED --eot--> CLOSED; verdict stays FAIL.
  - CLOSED: new events are ignored (not counted, not dropped); done=1. Draining continues. Exit only through grst.
  - FAIL and eot in the same cycle from RUN: the FAIL is accepted, the state goes to CLOSED, and verdict=FAIL.
- first_fail_end is written only once per reset.
- grst mid-operation: the FIFO contents are discarded immediately and rec_valid falls asynchronously.

Optional Feature:
- Macro: SVA_VERDICT_LATENCY_EN.
- When defined, adds outputs lat_min and lat_max (each TIMER_WIDTH).
  - Latency = end − start, modulo 2^TIMER_WIDTH.
  - Updated on every accepted SUCC or LAZY.
  - Reset values: lat_min all-ones, lat_max 0.
  - FAIL events do not update these outputs.
- When undefined: ports and logic are absent; other behaviour is identical.

Decomposition:
- Package sva_verdict_pkg:
  - verdict_kind_t enum (SUCC, FAIL, LAZY, RSVD).
  - verdict_t enum (PENDING, PASS, FAIL, VACUOUS).
  - tracker_state_t enum (RUN, FAILED, CLOSED).
  - Packed struct verdict_rec_t {kind, start, end}.
- One sub-module, sva_rec_fifo: parameterised sync FIFO of verdict_rec_t with full/empty and a same-cycle read/write rule.

Test Plan:
- Reset, then 3 SUCC events at periods 5, 6, 7 with rec_ready=1 → 3 records out, each 1 cycle after its write; succ_cnt=3; eot → verdict=PASS, done=1.
- FIFO_DEPTH=4, rec_ready=0, 6 LAZY events → lazy_cnt=6, drop_cnt=2; then rec_ready=1 → exactly 4 records drained, in order.
- SUCC at period 10, FAIL at 12, FAIL at 14, eot → verdict=FAIL, first_fail_end=12, fail_cnt=2.
- eot with no events → VACUOUS; subsequent SUCC is ignored and succ_cnt stays 0.
- TIMER_WIDTH=4, ev_start=14, event accepted at period 2 → rec_end=2; with SVA_VERDICT_LATENCY_EN, lat_min=lat_max=4.
- FAIL coincident with eot from RUN → CLOSED, verdict=FAIL. Separately, grst mid-drain → rec_valid=0 and all counters 0.
